// File: rtl/syscall_responder_pkg.sv
// Shared defines for the CPU and its syscall responder: opcode/funct
// encodings, syscall service codes, responder state encodings and a
// nibble-extraction helper used by the hex printer.
package syscall_responder_pkg;

    // CPU primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // CPU funct codes for OP_SPECIAL
    localparam logic [5:0] FUNCT_SLL     = 6'h00;
    localparam logic [5:0] FUNCT_JR      = 6'h08;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0] FUNCT_ADDU    = 6'h21;
    localparam logic [5:0] FUNCT_SUBU    = 6'h23;

    // Syscall service codes ($v0 values)
    localparam int SYS_PRINT_INT  = 1;
    localparam int SYS_EXIT       = 10;
    localparam int SYS_PRINT_CHAR = 11;

    // Responder state encodings
    localparam int W_SYS_STATE = 3;

    typedef enum logic [W_SYS_STATE-1:0] {
        SYS_IDLE = 3'd0,
        SYS_HEX  = 3'd1,
        SYS_NL   = 3'd2,
        SYS_CHAR = 3'd3,
        SYS_HALT = 3'd4
    } sys_state_t;

    // Byte appended after a printed integer
    localparam logic [7:0] ASCII_NL = 8'h0A;

    // Number of hex digits printed for one integer
    localparam int N_HEX_DIGITS = 8;

    // Select nibble idx (0 = least significant) of a 32-bit word
    function automatic logic [3:0] hex_nibble(input logic [31:0] word,
                                              input logic [2:0]  idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/syscall_responder_nibble_to_ascii.sv
// Combinational 4-bit to lowercase hex ASCII digit converter:
// 0-9 map to 0x30-0x39, a-f map to 0x61-0x66.
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Digits sit at '0'; letters at 'a' minus ten so 0xA lands on 'a'
    always_comb begin
        ascii = 8'h30;
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'h0, nibble};
        end else begin
            ascii = 8'h57 + {4'h0, nibble};
        end
    end

endmodule

// File: rtl/syscall_responder.sv
// Syscall responder: services print-integer, print-char and exit requests
// from the CPU and streams ASCII bytes to a console sink.
//
// Handshakes (both request and tx side): a transfer happens on a rising
// edge where valid and ready are both 1. The producer holds valid and its
// payload stable until that edge; ready never depends combinationally on
// valid. All outputs here come straight from registers.
module syscall_responder
    import syscall_responder_pkg::*;
#(
    parameter int NEWLINE = 1,
    parameter int W_CPU   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W_CPU-1:0] req_code,
    input  logic [W_CPU-1:0] req_arg,
    output logic             busy,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             halt,
    output logic             err,
    output sys_state_t       dbg_state,
    output logic [2:0]       dbg_digit,
    output logic [W_CPU-1:0] dbg_code
);

    // Registered state and outputs
    sys_state_t       state_q,     state_d;
    logic [2:0]       digit_q,     digit_d;
    logic [W_CPU-1:0] code_q,      code_d;
    logic [W_CPU-1:0] arg_q,       arg_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q,      busy_d;
    logic             tx_valid_q,  tx_valid_d;
    logic [7:0]       tx_data_q,   tx_data_d;
    logic             halt_q,      halt_d;
    logic             err_q,       err_d;

    // Handshake events
    logic accept;
    logic transfer;

    // Nibble converter: the FSM chooses which nibble feeds it each cycle
    logic [3:0] nib_sel;
    logic [7:0] nib_ascii;

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (nib_sel),
        .ascii  (nib_ascii)
    );

    assign accept   = req_valid && req_ready_q;
    assign transfer = tx_valid_q && tx_ready;

    // Next-state and next-output logic; the byte after a transfer is
    // prepared here so it appears on tx_data in the following cycle
    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        code_d     = code_q;
        arg_d      = arg_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        halt_d     = halt_q;
        err_d      = 1'b0;
        nib_sel    = hex_nibble(req_arg[31:0], 3'd7);

        case (state_q)
            SYS_IDLE: begin
                if (accept) begin
                    code_d = req_code;
                    arg_d  = req_arg;
                    if (req_code == W_CPU'(SYS_PRINT_INT)) begin
                        // First digit comes straight from the request word
                        state_d    = SYS_HEX;
                        digit_d    = 3'd7;
                        tx_valid_d = 1'b1;
                        tx_data_d  = nib_ascii;
                    end else if (req_code == W_CPU'(SYS_PRINT_CHAR)) begin
                        state_d    = SYS_CHAR;
                        tx_valid_d = 1'b1;
                        tx_data_d  = req_arg[7:0];
                    end else if (req_code == W_CPU'(SYS_EXIT)) begin
                        state_d = SYS_HALT;
                        halt_d  = 1'b1;
                    end else begin
                        // Unsupported service: flag it and stay ready
                        err_d = 1'b1;
                    end
                end
            end

            SYS_HEX: begin
                // Look ahead to the next lower digit of the latched word
                nib_sel = hex_nibble(arg_q[31:0], digit_q - 3'd1);
                if (transfer) begin
                    if (digit_q != 3'd0) begin
                        digit_d   = digit_q - 3'd1;
                        tx_data_d = nib_ascii;
                    end else if (NEWLINE != 0) begin
                        state_d   = SYS_NL;
                        tx_data_d = ASCII_NL;
                    end else begin
                        state_d    = SYS_IDLE;
                        tx_valid_d = 1'b0;
                    end
                end
            end

            SYS_NL: begin
                if (transfer) begin
                    state_d    = SYS_IDLE;
                    tx_valid_d = 1'b0;
                end
            end

            SYS_CHAR: begin
                if (transfer) begin
                    state_d    = SYS_IDLE;
                    tx_valid_d = 1'b0;
                end
            end

            SYS_HALT: begin
                // Only reset leaves this state
                tx_valid_d = 1'b0;
            end

            default: begin
                state_d    = SYS_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == SYS_IDLE);
        busy_d      = (state_d == SYS_HEX) || (state_d == SYS_NL) ||
                      (state_d == SYS_CHAR);
    end

    // State and output registers with synchronous active-low reset;
    // reset also drops any bytes still pending from an aborted request
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SYS_IDLE;
            digit_q     <= 3'd0;
            code_q      <= '0;
            arg_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            code_q      <= code_d;
            arg_q       <= arg_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign halt      = halt_q;
    assign err       = err_q;

    assign dbg_state = state_q;
    assign dbg_digit = digit_q;
    assign dbg_code  = code_q;

endmodule

// File: tb/tb_syscall_responder.sv
// Bench for syscall_responder: a byte-queue model of the console stream
// checked against the DUT every cycle, plus directed scenarios with
// hand-computed expectations.
module tb_syscall_responder;
    import syscall_responder_pkg::*;

    localparam int W_CPU   = 32;
    localparam int NEWLINE = 1;

    // Clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic [W_CPU-1:0]  req_code  = '0;
    logic [W_CPU-1:0]  req_arg   = '0;
    logic              tx_ready  = 1'b0;
    logic              req_ready;
    logic              busy;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              halt;
    logic              err;
    sys_state_t        dbg_state;
    logic [2:0]        dbg_digit;
    logic [W_CPU-1:0]  dbg_code;

    syscall_responder #(
        .NEWLINE (NEWLINE),
        .W_CPU   (W_CPU)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .req_arg   (req_arg),
        .busy      (busy),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .halt      (halt),
        .err       (err),
        .dbg_state (dbg_state),
        .dbg_digit (dbg_digit),
        .dbg_code  (dbg_code)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    // Scoreboard model: exp_q holds the bytes still owed to the console
    // for the request in progress; head of queue is what tx_data shows
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    bit m_up      = 1'b0;
    bit m_halt    = 1'b0;
    bit m_err     = 1'b0;
    bit m_stall   = 1'b0;
    bit started   = 1'b0;
    int stall_cycles = 0;

    function automatic bit model_ready();
        return m_up && !m_halt && (exp_q.size() == 0);
    endfunction

    task automatic model_step();
        bit    rdy;
        string s;
        rdy     = model_ready();
        m_stall = 1'b0;
        if (!rst) begin
            exp_q.delete();
            m_up   = 1'b0;
            m_halt = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (exp_q.size() != 0) begin
                if (tx_ready) log_q.push_back(exp_q.pop_front());
                else begin
                    m_stall = 1'b1;
                    stall_cycles++;
                end
            end else if (rdy && req_valid) begin
                case (req_code)
                    32'd1: begin
                        s = $sformatf("%08h", req_arg);
                        for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
                        if (NEWLINE != 0) exp_q.push_back(8'h0A);
                    end
                    32'd11:  exp_q.push_back(req_arg[7:0]);
                    32'd10:  m_halt = 1'b1;
                    default: m_err = 1'b1;
                endcase
            end
            m_up = 1'b1;
        end
        started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: every cycle, on the falling edge
    logic [7:0] prev_data = 8'h00;
    int tx_cycles   = 0;
    int busy_cycles = 0;
    int err_cycles  = 0;

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("req_ready", {31'b0, req_ready}, {31'b0, model_ready()});
            check("busy",      {31'b0, busy},      {31'b0, exp_q.size() != 0});
            check("tx_valid",  {31'b0, tx_valid},  {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) check("tx_data", {24'b0, tx_data}, {24'b0, exp_q[0]});
            if (m_stall) check("tx_data_stable", {24'b0, tx_data}, {24'b0, prev_data});
            check("halt", {31'b0, halt}, {31'b0, m_halt});
            check("err",  {31'b0, err},  {31'b0, m_err});
            prev_data = tx_data;
            if (tx_valid) tx_cycles++;
            if (busy) busy_cycles++;
            if (err) err_cycles++;
        end
    end

    // Driver tasks: inputs change 1 time unit after the falling edge
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        tx_cycles    = 0;
        busy_cycles  = 0;
        err_cycles   = 0;
        stall_cycles = 0;
        log_q.delete();
    endtask

    task automatic send(input logic [31:0] code, input logic [31:0] arg);
        req_valid = 1'b1;
        req_code  = code;
        req_arg   = arg;
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic check_log(input string name, input string exp);
        bit ok;
        ok = (log_q.size() == exp.len());
        for (int i = 0; i < exp.len(); i++)
            if (ok && (log_q[i] != exp[i])) ok = 1'b0;
        check({name, "_len"}, log_q.size(), exp.len());
        check({name, "_bytes"}, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b0;
        tx_ready = 1'b1;
        tick(2);
        check("reset_req_ready", {31'b0, req_ready}, 32'd0);
        check("reset_tx_data",   {24'b0, tx_data},   32'h00);
        rst = 1'b1;
        tick(1);
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Print integer, sink always ready
        clear_counts();
        send(32'd1, 32'h12AB00FF);
        tick(9);
        check("int_tx_cycles", tx_cycles, 32'd9);
        check("int_ready_after", {31'b0, req_ready}, 32'd1);
        check_log("int_log", "12ab00ff\n");

        // Print integer, sink alternating ready/stall
        clear_counts();
        tx_ready = 1'b0;
        send(32'd1, 32'hDEADBEEF);
        for (int i = 0; i < 24; i++) begin
            tx_ready = ~tx_ready;
            tick(1);
        end
        tx_ready = 1'b1;
        tick(1);
        check_log("stall_log", "deadbeef\n");
        check("stall_count", stall_cycles, 32'd8);
        check("stall_ready_after", {31'b0, req_ready}, 32'd1);

        // Print char
        clear_counts();
        send(32'd11, 32'h00000041);
        tick(3);
        check("char_busy_cycles", busy_cycles, 32'd1);
        check("char_tx_cycles", tx_cycles, 32'd1);
        check_log("char_log", "A");
        check("char_ready_after", {31'b0, req_ready}, 32'd1);

        // Unsupported code
        clear_counts();
        send(32'd7, 32'h0);
        check("err_pulse", {31'b0, err}, 32'd1);
        check("err_ready", {31'b0, req_ready}, 32'd1);
        tick(1);
        check("err_cleared", {31'b0, err}, 32'd0);
        tick(2);
        check("err_cycles", err_cycles, 32'd1);
        check("err_tx_cycles", tx_cycles, 32'd0);
        check("err_ready_after", {31'b0, req_ready}, 32'd1);

        // Reset during the fourth digit
        clear_counts();
        send(32'd1, 32'h12AB00FF);
        tick(3);
        check("mid_fourth_digit", {24'b0, tx_data}, 32'h62);
        rst = 1'b0;
        tick(1);
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("mid_rst_busy",      {31'b0, busy},      32'd0);
        check("mid_rst_tx_valid",  {31'b0, tx_valid},  32'd0);
        check("mid_rst_tx_data",   {24'b0, tx_data},   32'h00);
        check("mid_rst_halt",      {31'b0, halt},      32'd0);
        check("mid_rst_err",       {31'b0, err},       32'd0);
        rst = 1'b1;
        tick(12);
        check_log("mid_rst_log", "12a");
        check("mid_rst_tx_cycles", tx_cycles, 32'd4);
        check("mid_rst_ready_after", {31'b0, req_ready}, 32'd1);

        // Exit, then a request that must never be taken
        clear_counts();
        send(32'd10, 32'h0);
        check("halt_set", {31'b0, halt}, 32'd1);
        check("halt_not_ready", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b1;
        req_code  = 32'd1;
        req_arg   = 32'h0BADF00D;
        tick(10);
        req_valid = 1'b0;
        check("halt_tx_cycles", tx_cycles, 32'd0);
        check("halt_busy_cycles", busy_cycles, 32'd0);
        check("halt_sticky", {31'b0, halt}, 32'd1);
        check_log("halt_log", "");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/syscall_responder.md
SYSCALL_RESPONDER -- requirements
Module: syscall_responder

Interface
REQ-001 SHALL have parameter NEWLINE, default 1, meaning: when 1, a print-integer request appends byte 0x0A after its hex digits.
REQ-002 SHALL have parameter W_CPU, default 32, meaning: width of the request code and argument words.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  CPU presents a syscall request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_code  input  W_CPU  service code ($v0 value).
REQ-008 SHALL have port req_arg  input  W_CPU  argument ($a0 value).
REQ-009 SHALL have port busy  output  1  request in progress; the CPU stalls on it.
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a valid output byte.
REQ-011 SHALL have port tx_ready  input  1  console sink accepts the byte.
REQ-012 SHALL have port tx_data  output  8  ASCII output byte.
REQ-013 SHALL have port halt  output  1  exit requested; sticky.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an unsupported code.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, latching req_code and req_arg.
REQ-016 SHALL implement states IDLE, HEX, NL, CHAR and HALT; req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in HEX, NL and CHAR.
REQ-017 SHALL handle code 1 (print integer) as IDLE->HEX and emit 8 lowercase hex ASCII digits of req_arg, most-significant nibble first, using a 3-bit digit counter running 7 down to 0.
REQ-018 SHALL, in HEX after the digit-0 transfer, go to NL when NEWLINE=1, otherwise to IDLE.
REQ-019 SHALL, in NL, emit byte 0x0A and go to IDLE after it transfers.
REQ-020 SHALL handle code 11 (print char) as IDLE->CHAR, emit req_arg[7:0], then go to IDLE.
REQ-021 SHALL handle code 10 (exit) as IDLE->HALT and set halt=1 on the edge after acceptance; HALT SHALL be left only by reset.
REQ-022 SHALL handle any other code by pulsing err for exactly the cycle after acceptance, emitting nothing, and staying in IDLE.
REQ-023 SHALL assert tx_valid in the cycle after acceptance, carrying the first byte.
REQ-024 SHALL complete a byte transfer only on an edge where tx_valid and tx_ready are both 1; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-025 SHALL output the next byte in the cycle after a transfer; back-to-back transfers at one byte per cycle SHALL be sustained.
REQ-026 SHALL return req_ready to 1 in the cycle after the last byte transfers; a code-1 request with tx_ready held at 1 SHALL take 9 cycles of tx_valid when NEWLINE=1.
REQ-027 SHALL ignore req_valid whenever req_ready=0; no request is queued.
REQ-028 SHALL, in HALT, hold tx_valid=0, req_ready=0 and busy=0.
REQ-029 SHALL drive all outputs from registers.

Reset
REQ-030 SHALL, on an edge with rst=0, enter IDLE and clear the latched code and argument.
REQ-031 SHALL, on reset, set req_ready=0, busy=0, tx_valid=0, tx_data=0x00, halt=0 and err=0.
REQ-032 SHALL raise req_ready to 1 on the first edge with rst=1.
REQ-033 SHALL, on reset mid-transfer, abort the request; any remaining bytes SHALL NOT be emitted after reset is released.

Structure
REQ-034 SHALL take the service codes SYS_PRINT_INT=1, SYS_EXIT=10, SYS_PRINT_CHAR=11 from the shared defines header, alongside the CPU's funct and opcode defines.
REQ-035 SHALL take the state encodings and their width W_SYS_STATE from the same shared defines header.
REQ-036 SHALL use one combinational sub-module, nibble_to_ascii, mapping 4 bits to 0x30-0x39 and 0x61-0x66.

Verification
REQ-037 Bench SHALL cover: code=1, arg=0x12AB00FF, tx_ready=1 -> bytes "12ab00ff" then 0x0A on 9 consecutive cycles; req_ready=1 on the next cycle.
REQ-038 Bench SHALL cover: code=1, arg=0xDEADBEEF, tx_ready toggled 1/0 each cycle -> "deadbeef" plus 0x0A, with tx_data stable during every stalled cycle.
REQ-039 Bench SHALL cover: code=11, arg=0x00000041 -> a single byte 0x41; busy high for exactly 1 cycle with tx_ready=1.
REQ-040 Bench SHALL cover: code=10 -> halt=1 on the next edge; a later code=1 request with req_valid=1 is never accepted and tx_valid stays 0.
REQ-041 Bench SHALL cover: code=7 -> err pulses for 1 cycle, no tx_valid, and req_ready is still 1 on the following cycle.
REQ-042 Bench SHALL cover: rst=0 driven during the 4th digit of a code-1 request -> all outputs at reset values on the next edge, and no further bytes after release.
